io_req_ctrl: RTL and testbench

CPU-side requester for the I/O bus slave port. It accepts single-cycle I/O access strobes from the fast-side bus decoder and drives the IOREQ/IOWE/IOLDS/IOUDS/nADLEEN request interface of the PDS I/O bus master. It tracks the master's IOACT through a synchronizer and returns read completion or posted-write acceptance to the CPU side. Only one bus cycle is in flight at a time, because the PDS address/data output latch holds a single entry.

---
 rtl/io_req_ctrl.sv | 156 +++++++++++++++
 tb/tb_io_req_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/io_req_ctrl.sv
// CPU-side requester for the PDS I/O bus master: latches one access at a time,
// drives IOREQ/IOWE/IOLDS/IOUDS/nADLEEN and returns read/write completion.
module io_req_ctrl #(
    parameter int LATCH_CYCLES = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int POST_WRITES  = 1
) (
    input  logic CLK,
    input  logic nRES,
    input  logic REQ_VALID,
    input  logic REQ_WE,
    input  logic REQ_LDS,
    input  logic REQ_UDS,
    output logic REQ_BUSY,
    output logic RD_ACK,
    output logic WR_ACK,
    output logic PWR_PEND,
    output logic IOREQ,
    output logic IOWE,
    output logic IOLDS,
    output logic IOUDS,
    output logic nADLEEN,
    input  logic IOACT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] CNT_INIT = 3'(LATCH_CYCLES - 1);
    localparam logic       POSTED   = (POST_WRITES != 0);

    logic [2:0]             state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic ioreq_q, ioreq_d;
    logic iowe_q, iowe_d;
    logic iolds_q, iolds_d;
    logic iouds_q, iouds_d;
    logic nadleen_q, nadleen_d;
    logic busy_q, busy_d;
    logic rd_ack_q, rd_ack_d;
    logic wr_ack_q, wr_ack_d;
    logic pend_q, pend_d;
    logic io_act_s;

    assign io_act_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], IOACT};
        state_d   = state_q;
        cnt_d     = cnt_q;
        ioreq_d   = ioreq_q;
        iowe_d    = iowe_q;
        iolds_d   = iolds_q;
        iouds_d   = iouds_q;
        nadleen_d = nadleen_q;
        busy_d    = busy_q;
        pend_d    = pend_q;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A busy master means the previous bus cycle has not drained yet.
                if (REQ_VALID && !io_act_s) begin
                    state_d   = S_LATCH;
                    iowe_d    = REQ_WE;
                    iolds_d   = REQ_LDS;
                    iouds_d   = REQ_UDS;
                    nadleen_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_INIT;
                end
            end
            S_LATCH: begin
                if (cnt_q == 3'd0) begin
                    state_d   = S_REQ;
                    ioreq_d   = 1'b1;
                    nadleen_d = 1'b1;
                    if (POSTED && iowe_q) begin
                        wr_ack_d = 1'b1;
                        pend_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_REQ: begin
                if (io_act_s) begin
                    state_d = S_ACT;
                    ioreq_d = 1'b0;
                end
            end
            S_ACT: begin
                // A one-cycle IOACT blip lands here too and still retires the cycle.
                if (!io_act_s) begin
                    state_d = S_DONE;
                    if (!iowe_q) begin
                        rd_ack_d = 1'b1;
                    end else if (!POSTED) begin
                        wr_ack_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                pend_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            sync_q    <= '0;
            ioreq_q   <= 1'b0;
            iowe_q    <= 1'b0;
            iolds_q   <= 1'b0;
            iouds_q   <= 1'b0;
            nadleen_q <= 1'b1;
            busy_q    <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            ioreq_q   <= ioreq_d;
            iowe_q    <= iowe_d;
            iolds_q   <= iolds_d;
            iouds_q   <= iouds_d;
            nadleen_q <= nadleen_d;
            busy_q    <= busy_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            pend_q    <= pend_d;
        end
    end

    assign IOREQ    = ioreq_q;
    assign IOWE     = iowe_q;
    assign IOLDS    = iolds_q;
    assign IOUDS    = iouds_q;
    assign nADLEEN  = nadleen_q;
    assign REQ_BUSY = busy_q;
    assign RD_ACK   = rd_ack_q;
    assign WR_ACK   = wr_ack_q;
    assign PWR_PEND = pend_q;

endmodule

// File: tb/tb_io_req_ctrl.sv
// Directed bench for io_req_ctrl: a posted-write instance and a non-posted
// instance run the same stimulus; expected values are hand-derived per cycle.
module tb_io_req_ctrl;

    logic clk = 1'b0;
    logic nres, req_valid, req_we, req_lds, req_uds, ioact;
    logic busy1, rd1, wr1, pend1, ioreq1, iowe1, iolds1, iouds1, nadl1;
    logic busy0, rd0, wr0, pend0, ioreq0, iowe0, iolds0, iouds0, nadl0;

    int checks = 0;
    int errors = 0;
    int rd_cnt1 = 0, wr_cnt1 = 0, rd_cnt0 = 0, wr_cnt0 = 0, both_cnt = 0;

    always #5 clk = ~clk;

    io_req_ctrl #(.LATCH_CYCLES(2), .SYNC_STAGES(2), .POST_WRITES(1)) dut_post (
        .CLK(clk), .nRES(nres), .REQ_VALID(req_valid), .REQ_WE(req_we),
        .REQ_LDS(req_lds), .REQ_UDS(req_uds), .REQ_BUSY(busy1), .RD_ACK(rd1),
        .WR_ACK(wr1), .PWR_PEND(pend1), .IOREQ(ioreq1), .IOWE(iowe1),
        .IOLDS(iolds1), .IOUDS(iouds1), .nADLEEN(nadl1), .IOACT(ioact)
    );

    io_req_ctrl #(.LATCH_CYCLES(2), .SYNC_STAGES(2), .POST_WRITES(0)) dut_npost (
        .CLK(clk), .nRES(nres), .REQ_VALID(req_valid), .REQ_WE(req_we),
        .REQ_LDS(req_lds), .REQ_UDS(req_uds), .REQ_BUSY(busy0), .RD_ACK(rd0),
        .WR_ACK(wr0), .PWR_PEND(pend0), .IOREQ(ioreq0), .IOWE(iowe0),
        .IOLDS(iolds0), .IOUDS(iouds0), .nADLEEN(nadl0), .IOACT(ioact)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic we, input logic lds, input logic uds);
        req_valid = 1'b1;
        req_we    = we;
        req_lds   = lds;
        req_uds   = uds;
        tick();
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nres === 1'b1) begin
            rd_cnt1  += int'(rd1);
            wr_cnt1  += int'(wr1);
            rd_cnt0  += int'(rd0);
            wr_cnt0  += int'(wr0);
            both_cnt += int'((rd1 & wr1) | (rd0 & wr0));
        end
    end

    initial begin
        nres = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_lds = 1'b0; req_uds = 1'b0; ioact = 1'b0;
        tick(3);
        check_eq("rst_ioreq", ioreq1, 0);
        check_eq("rst_nadleen", nadl1, 1);
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_ack", rd1 | wr1, 0);
        check_eq("rst_pend", pend1, 0);
        check_eq("rst_iowe", iowe1, 0);
        nres = 1'b1;

        // read, both lanes
        strobe(1'b0, 1'b1, 1'b1);
        check_eq("t1_c1_nadleen", nadl1, 0);
        check_eq("t1_c1_busy", busy1, 1);
        check_eq("t1_c1_ioreq", ioreq1, 0);
        check_eq("t1_c1_quals", {iowe1, iolds1, iouds1}, 3'b011);
        tick();
        check_eq("t1_c2_nadleen", nadl1, 0);
        check_eq("t1_c2_ioreq", ioreq1, 0);
        tick();
        check_eq("t1_c3_nadleen", nadl1, 1);
        check_eq("t1_c3_ioreq", ioreq1, 1);
        check_eq("t1_c3_wrack", wr1, 0);
        ioact = 1'b1;
        tick(2);
        check_eq("t1_c5_ioreq", ioreq1, 1);
        tick();
        check_eq("t1_c6_ioreq", ioreq1, 0);
        ioact = 1'b0;
        tick(2);
        check_eq("t1_c8_rdack", rd1, 0);
        tick();
        check_eq("t1_done_rdack1", rd1, 1);
        check_eq("t1_done_rdack0", rd0, 1);
        check_eq("t1_done_wrack0", wr0, 0);
        check_eq("t1_done_busy", busy1, 1);
        tick();
        check_eq("t1_after_rdack", rd1, 0);
        check_eq("t1_after_busy", busy1, 0);
        $display("txn read lds+uds complete");

        // write, upper lane only; read strobe during the cycle must be ignored
        strobe(1'b1, 1'b0, 1'b1);
        check_eq("t2_c1_quals", {iowe1, iolds1, iouds1}, 3'b101);
        tick(2);
        check_eq("t2_c3_ioreq", ioreq1, 1);
        check_eq("t2_c3_wrack_post", wr1, 1);
        check_eq("t2_c3_pend_post", pend1, 1);
        check_eq("t2_c3_wrack_npost", wr0, 0);
        check_eq("t2_c3_pend_npost", pend0, 0);
        check_eq("t2_c3_rdack", rd1, 0);
        tick();
        check_eq("t2_c4_wrack_post", wr1, 0);
        ioact = 1'b1;
        strobe(1'b0, 1'b1, 1'b0);
        check_eq("t4_ignored_quals", {iowe1, iolds1, iouds1}, 3'b101);
        check_eq("t4_ignored_busy", busy1, 1);
        tick();
        check_eq("t2_c6_ioreq", ioreq1, 1);
        tick();
        check_eq("t2_c7_ioreq", ioreq1, 0);
        ioact = 1'b0;
        tick(2);
        check_eq("t3_c9_wrack_npost", wr0, 0);
        check_eq("t2_c9_pend", pend1, 1);
        tick();
        check_eq("t3_done_wrack_npost", wr0, 1);
        check_eq("t2_done_wrack_post", wr1, 0);
        check_eq("t2_done_rdack", rd1 | rd0, 0);
        check_eq("t2_done_quals", {iowe1, iolds1, iouds1}, 3'b101);
        check_eq("t2_done_pend", pend1, 1);
        tick();
        check_eq("t2_after_pend", pend1, 0);
        check_eq("t2_after_busy", busy1, 0);
        check_eq("t2_after_wrack_npost", wr0, 0);
        $display("txn write uds posted/non-posted complete");

        // re-strobe right after DONE: IOREQ rises 4 cycles after DONE
        strobe(1'b0, 1'b1, 1'b1);
        tick();
        check_eq("t4_spacing_ioreq_lo", ioreq1, 0);
        tick();
        check_eq("t4_spacing_ioreq_hi", ioreq1, 1);

        // IOACT never comes: IOREQ stays up, strobes change nothing
        tick(20);
        check_eq("t6_stuck_ioreq", ioreq1, 1);
        check_eq("t6_stuck_busy", busy1, 1);
        strobe(1'b1, 1'b0, 1'b0);
        tick(3);
        check_eq("t6_stuck_quals", {iowe1, iolds1, iouds1}, 3'b011);
        check_eq("t6_stuck_ioreq2", ioreq1, 1);
        check_eq("t6_stuck_nadleen", nadl1, 1);
        $display("txn read stuck in request phase");

        // reset while in ACT with IOACT high
        ioact = 1'b1;
        tick(3);
        check_eq("t5_act_ioreq", ioreq1, 0);
        nres = 1'b0;
        tick();
        check_eq("t5_rst_ioreq", ioreq1, 0);
        check_eq("t5_rst_nadleen", nadl1, 1);
        check_eq("t5_rst_busy", busy1, 0);
        check_eq("t5_rst_ack", rd1 | wr1 | rd0 | wr0, 0);
        check_eq("t5_rst_pend", pend1, 0);
        nres = 1'b1;
        tick(2);
        strobe(1'b0, 1'b1, 1'b1);
        check_eq("t5_blocked_busy", busy1, 0);
        check_eq("t5_blocked_nadleen", nadl1, 1);
        ioact = 1'b0;
        tick(2);
        strobe(1'b1, 1'b0, 1'b0);
        check_eq("t5_accept_busy", busy1, 1);
        check_eq("t5_accept_nadleen", nadl1, 0);
        check_eq("t5_accept_quals", {iowe1, iolds1, iouds1}, 3'b100);
        tick(2);
        check_eq("t5_c3_ioreq", ioreq1, 1);
        check_eq("t5_c3_wrack_post", wr1, 1);
        ioact = 1'b1;
        tick();
        ioact = 1'b0;
        tick(2);
        check_eq("t5_glitch_ioreq", ioreq1, 0);
        tick();
        check_eq("t5_glitch_wrack_npost", wr0, 1);
        check_eq("t5_glitch_rdack", rd0, 0);
        tick();
        check_eq("t5_glitch_busy", busy1, 0);
        $display("txn no-lane write after reset complete");

        check_eq("tot_rdack_post", rd_cnt1, 1);
        check_eq("tot_rdack_npost", rd_cnt0, 1);
        check_eq("tot_wrack_post", wr_cnt1, 2);
        check_eq("tot_wrack_npost", wr_cnt0, 2);
        check_eq("tot_ack_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
